regfile_write_arbiter: RTL and testbench

- Drives the single register-file write port (reg_iswrite_enable / Write_regAddress / Write_dataValue) of the pipeline processor.
- Merges two write sources into one write per cycle:
  - writeback-stage results, buffered in a small FIFO;
  - the exception/interrupt return address, which is written to $26.
- Filters writes to $0 and to the reserved $26 from the pipeline source.
- Exposes backpressure to the writeback stage.

---
 rtl/regfile_write_arbiter_if.sv | 41 ++++
 rtl/regfile_write_arbiter.sv | 133 +++++++++++++
 tb/tb_regfile_write_arbiter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Bundle of the arbiter's handshake and register-file write signals.
//
// Handshake rule (both request channels): a transfer happens at a rising
// clock edge where valid and ready are both high. The requester holds
// valid/payload stable until that edge. Ready depends only on registered
// state, never combinationally on valid.
interface regfile_write_arbiter_if #(
  parameter int CNT_W = 3
);
  // writeback request channel
  logic             wb_valid;
  logic             wb_ready;
  logic [4:0]       wb_addr;
  logic [31:0]      wb_data;
  // exception return-address channel
  logic             exc_valid;
  logic             exc_ready;
  logic [31:0]      exc_pc;
  // register-file write port
  logic             reg_iswrite_enable;
  logic [4:0]       Write_regAddress;
  logic [31:0]      Write_dataValue;
  // status
  logic [CNT_W-1:0] fifo_count;
  logic             epc_pending;
  logic [7:0]       drop_count;
  // debug view of the derived state: 0 IDLE, 1 DRAIN, 2 EPC
  logic [1:0]       dbg_state;

  modport slave (
    input  wb_valid, wb_addr, wb_data, exc_valid, exc_pc,
    output wb_ready, exc_ready, reg_iswrite_enable, Write_regAddress,
           Write_dataValue, fifo_count, epc_pending, drop_count, dbg_state
  );

  modport master (
    output wb_valid, wb_addr, wb_data, exc_valid, exc_pc,
    input  wb_ready, exc_ready, reg_iswrite_enable, Write_regAddress,
           Write_dataValue, fifo_count, epc_pending, drop_count, dbg_state
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Register-file write arbiter: merges writeback results (queued in a small
// FIFO) with the exception return address (written to $26) into one
// registered write per cycle. Pipeline writes to $0/$26 are dropped and
// counted. EPC has strict priority over queued pipeline writes.
// Optional build macro WB_BYPASS_EN: when IDLE, an accepted write issues at
// its accept edge instead of passing through the FIFO.
module regfile_write_arbiter #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  regfile_write_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_EPC   = 2'd2
  } state_e;

  logic [4:0]       addr_mem_q [DEPTH];
  logic [31:0]      data_mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             epc_pending_q;
  logic [31:0]      epc_reg_q;
  logic [7:0]       drop_q;
  logic             we_q;
  logic [4:0]       waddr_q;
  logic [31:0]      wdata_q;

  logic             wb_ready, exc_ready;
  logic             wb_acc, wb_filt, cand, exc_acc;
  logic             push, pop, bypass;
  logic             issue_en_d;
  logic [4:0]       issue_addr_d;
  logic [31:0]      issue_data_d;
  state_e           state;

  // Ready comes from registered state only, so a pop at a full edge cannot
  // reopen the FIFO in the same cycle.
  assign wb_ready  = (count_q != CNT_W'(DEPTH));
  assign exc_ready = !epc_pending_q;
  assign wb_acc    = bus.wb_valid && wb_ready;
  assign wb_filt   = (bus.wb_addr == 5'd0) || (bus.wb_addr == 5'd26);
  assign cand      = wb_acc && !wb_filt;
  assign exc_acc   = bus.exc_valid && exc_ready;
  assign push      = cand && !bypass;

  // Strict-priority selection of this edge's write: EPC, FIFO head, bypass.
  always_comb begin
    issue_en_d   = 1'b0;
    issue_addr_d = 5'd0;
    issue_data_d = 32'd0;
    pop          = 1'b0;
    bypass       = 1'b0;
    if (epc_pending_q) begin
      issue_en_d   = 1'b1;
      issue_addr_d = 5'd26;
      issue_data_d = epc_reg_q;
    end else if (count_q != '0) begin
      pop          = 1'b1;
      issue_en_d   = 1'b1;
      issue_addr_d = addr_mem_q[rd_ptr_q];
      issue_data_d = data_mem_q[rd_ptr_q];
    end
`ifdef WB_BYPASS_EN
    else if (cand) begin
      bypass       = 1'b1;
      issue_en_d   = 1'b1;
      issue_addr_d = bus.wb_addr;
      issue_data_d = bus.wb_data;
    end
`endif
  end

  // Derived state for debug visibility.
  always_comb begin
    if (epc_pending_q)       state = ST_EPC;
    else if (count_q != '0)  state = ST_DRAIN;
    else                     state = ST_IDLE;
  end

  // FIFO storage; contents need no reset because count_q gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[wr_ptr_q] <= bus.wb_addr;
      data_mem_q[wr_ptr_q] <= bus.wb_data;
    end
  end

  // Pointers, occupancy, EPC capture, drop counter and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      epc_pending_q <= 1'b0;
      epc_reg_q     <= 32'd0;
      drop_q        <= 8'd0;
      we_q          <= 1'b0;
      waddr_q       <= 5'd0;
      wdata_q       <= 32'd0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
      if (exc_acc) begin
        epc_pending_q <= 1'b1;
        epc_reg_q     <= bus.exc_pc;
      end else if (epc_pending_q) begin
        epc_pending_q <= 1'b0;
      end
      if (wb_acc && wb_filt && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
      we_q    <= issue_en_d;
      waddr_q <= issue_addr_d;
      wdata_q <= issue_data_d;
    end
  end

  assign bus.wb_ready           = wb_ready;
  assign bus.exc_ready          = exc_ready;
  assign bus.reg_iswrite_enable = we_q;
  assign bus.Write_regAddress   = waddr_q;
  assign bus.Write_dataValue    = wdata_q;
  assign bus.fifo_count         = count_q;
  assign bus.epc_pending        = epc_pending_q;
  assign bus.drop_count         = drop_q;
  assign bus.dbg_state          = state;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed testbench for regfile_write_arbiter. Cycle-exact expectations
// follow the WB_BYPASS_EN build setting; a write monitor checks every issued
// write against expected queues of pipeline writes and EPC values.
module tb_regfile_write_arbiter;
  logic clk;
  logic reset;

  regfile_write_arbiter_if #(.CNT_W(3)) bus ();

  regfile_write_arbiter #(.DEPTH(4), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_total = 0;
  int n_pass  = 0;
  logic [36:0] exp_q     [$];
  logic [31:0] exp_epc_q [$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_total++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
  endtask

  // driver tasks
  task automatic idle_inputs();
    bus.wb_valid  = 1'b0;
    bus.wb_addr   = 5'd0;
    bus.wb_data   = 32'd0;
    bus.exc_valid = 1'b0;
    bus.exc_pc    = 32'd0;
  endtask

  task automatic drive_wb(input logic [4:0] a, input logic [31:0] d);
    bus.wb_valid = 1'b1;
    bus.wb_addr  = a;
    bus.wb_data  = d;
  endtask

  function automatic logic [37:0] wr_now();
    return {bus.reg_iswrite_enable, bus.Write_regAddress, bus.Write_dataValue};
  endfunction

  // scoreboard: every issued write must match the head of its queue
  always @(negedge clk) begin
    if (reset && bus.reg_iswrite_enable) begin
      if (bus.Write_regAddress == 5'd26) begin
        if (exp_epc_q.size() == 0) check("epc_spurious", 1, 0);
        else check("epc_wr", bus.Write_dataValue, exp_epc_q.pop_front());
      end else begin
        if (exp_q.size() == 0) check("wb_spurious", 1, 0);
        else check("wb_wr", {bus.Write_regAddress, bus.Write_dataValue}, exp_q.pop_front());
      end
    end
  end

  initial begin
    int acc_n;
    int max_cnt;
    logic full_seen;

    reset = 1'b0;
    idle_inputs();

    // reset with random inputs
    for (int i = 0; i < 3; i++) begin
      bus.wb_valid  = 1'($urandom_range(0, 1));
      bus.wb_addr   = 5'($urandom_range(0, 31));
      bus.wb_data   = $urandom;
      bus.exc_valid = 1'($urandom_range(0, 1));
      bus.exc_pc    = $urandom;
      @(negedge clk);
    end
    check("rst_wr", wr_now(), 38'd0);
    check("rst_cnt", bus.fifo_count, 0);
    check("rst_epc", bus.epc_pending, 0);
    check("rst_drop", bus.drop_count, 0);
    check("rst_state", bus.dbg_state, 0);
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_we", bus.reg_iswrite_enable, 0);

    // latency of a single write
    drive_wb(5'd5, 32'h1234);
    exp_q.push_back({5'd5, 32'h1234});
    @(negedge clk);
    idle_inputs();
`ifdef WB_BYPASS_EN
    check("lat_c1", wr_now(), {1'b1, 5'd5, 32'h1234});
    check("lat_c1_cnt", bus.fifo_count, 0);
    @(negedge clk);
    check("lat_c2", wr_now(), 38'd0);
`else
    check("lat_c1", wr_now(), 38'd0);
    check("lat_c1_cnt", bus.fifo_count, 1);
    check("lat_c1_state", bus.dbg_state, 1);
    @(negedge clk);
    check("lat_c2", wr_now(), {1'b1, 5'd5, 32'h1234});
`endif
    check("lat_cnt", bus.fifo_count, 0);
    @(negedge clk);

    // filtering and drop-count saturation
    drive_wb(5'd0, 32'hFF);
    @(negedge clk);
    drive_wb(5'd26, 32'hEE);
    @(negedge clk);
    idle_inputs();
    check("drop_two", bus.drop_count, 2);
    check("drop_cnt", bus.fifo_count, 0);
    for (int i = 0; i < 253; i++) begin
      drive_wb((i % 2 == 0) ? 5'd0 : 5'd26, 32'(i));
      @(negedge clk);
    end
    idle_inputs();
    check("drop_255", bus.drop_count, 255);
    for (int i = 0; i < 45; i++) begin
      drive_wb((i % 2 == 0) ? 5'd26 : 5'd0, 32'(i));
      @(negedge clk);
    end
    idle_inputs();
    check("drop_sat", bus.drop_count, 255);
    @(negedge clk);

    // exception priority over queued writes
    check("excrdy_pre", bus.exc_ready, 1);
    drive_wb(5'd7, 32'hA);
    bus.exc_valid = 1'b1;
    bus.exc_pc    = 32'h0040_0010;
    exp_q.push_back({5'd7, 32'hA});
    exp_epc_q.push_back(32'h0040_0010);
    @(negedge clk);
    bus.exc_valid = 1'b0;
    drive_wb(5'd8, 32'hB);
    exp_q.push_back({5'd8, 32'hB});
    check("excrdy_c1", bus.exc_ready, 0);
    check("exc_state", bus.dbg_state, 2);
`ifdef WB_BYPASS_EN
    check("exc_c1", wr_now(), {1'b1, 5'd7, 32'hA});
`else
    check("exc_c1", wr_now(), 38'd0);
`endif
    @(negedge clk);
    idle_inputs();
    check("excrdy_c2", bus.exc_ready, 1);
    check("exc_c2", wr_now(), {1'b1, 5'd26, 32'h0040_0010});
    @(negedge clk);
`ifdef WB_BYPASS_EN
    check("exc_c3", wr_now(), {1'b1, 5'd8, 32'hB});
    @(negedge clk);
    check("exc_c4", wr_now(), 38'd0);
`else
    check("exc_c3", wr_now(), {1'b1, 5'd7, 32'hA});
    @(negedge clk);
    check("exc_c4", wr_now(), {1'b1, 5'd8, 32'hB});
`endif
    @(negedge clk);
    check("exc_c5", wr_now(), 38'd0);

    // full FIFO and ordering under repeated EPC stalls
    acc_n = 0;
    max_cnt = 0;
    full_seen = 1'b0;
    for (int cyc = 0; cyc < 100 && acc_n < 12; cyc++) begin
      drive_wb(5'(acc_n + 1), 32'hD000_0000 | 32'(acc_n + 1));
      bus.exc_valid = 1'b1;
      bus.exc_pc    = 32'h0040_0100;
      if (int'(bus.fifo_count) > max_cnt) max_cnt = int'(bus.fifo_count);
      if (bus.fifo_count == 3'd4 && !bus.wb_ready) full_seen = 1'b1;
      if (bus.wb_ready) begin
        exp_q.push_back({5'(acc_n + 1), 32'hD000_0000 | 32'(acc_n + 1)});
        acc_n++;
      end
      if (bus.exc_ready) exp_epc_q.push_back(32'h0040_0100);
      @(negedge clk);
    end
    idle_inputs();
    check("full_accepted", acc_n, 12);
    check("full_seen", full_seen, 1);
    check("full_max_cnt", max_cnt, 4);
    for (int i = 0; i < 40 && (bus.fifo_count != 0 || bus.epc_pending); i++) @(negedge clk);
    @(negedge clk);
    check("drain_cnt", bus.fifo_count, 0);
    check("drain_wb_left", exp_q.size(), 0);
    check("drain_epc_left", exp_epc_q.size(), 0);

    // reset while draining
    for (int cyc = 0; cyc < 30 && bus.fifo_count != 3'd3; cyc++) begin
      drive_wb(5'(cyc % 5 + 1), 32'hC000_0000 | 32'(cyc));
      bus.exc_valid = 1'b1;
      bus.exc_pc    = 32'h0040_0200;
      if (bus.wb_ready) exp_q.push_back({5'(cyc % 5 + 1), 32'hC000_0000 | 32'(cyc)});
      if (bus.exc_ready) exp_epc_q.push_back(32'h0040_0200);
      @(negedge clk);
    end
    idle_inputs();
    check("mid_fill", bus.fifo_count, 3);
    #2;
    reset = 1'b0;
    #1;
    exp_q.delete();
    exp_epc_q.delete();
    check("mid_rst_wr", wr_now(), 38'd0);
    check("mid_rst_cnt", bus.fifo_count, 0);
    check("mid_rst_epc", bus.epc_pending, 0);
    check("mid_rst_drop", bus.drop_count, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_we", bus.reg_iswrite_enable, 0);
    check("post_rst_cnt", bus.fifo_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
